// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the serial pattern detector.
// Holds the control-state encoding and the cfg_len width helper.
package seq_det_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } det_state_t;

    // Bits needed to hold a length in 0..max_len.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_prefix_match.sv
// Next-progress computation for the pattern detector (combinational).
// Ports: pattern/len (config), prog (current progress), history (newest
// accepted bit at [0]), new_bit; next_prog = longest matching prefix.
module seq_prefix_match
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    localparam int LEN_W = len_w(MAX_LEN)
) (
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic [LEN_W-1:0]   prog,
    input  logic [MAX_LEN-1:0] history,
    input  logic               new_bit,
    output logic [LEN_W-1:0]   next_prog
);

    logic [MAX_LEN:0] sfx;
    logic [MAX_LEN:0] pat_ext;
    logic [MAX_LEN:0] one;
    logic [MAX_LEN:0] mask;
    logic [MAX_LEN:0] pref;
    int               lim;
    logic             found;

    assign sfx     = {history, new_bit};
    assign pat_ext = {1'b0, pattern};
    assign one     = {{MAX_LEN{1'b0}}, 1'b1};

    // A suffix longer than prog+1 cannot match: the bits before the
    // current progress were either cleared or already proven useless.
    always_comb begin
        next_prog = '0;
        found     = 1'b0;
        mask      = '0;
        pref      = '0;
        lim       = int'(prog) + 1;
        if (lim > int'(len)) begin
            lim = int'(len);
        end
        for (int k = MAX_LEN; k >= 1; k--) begin
            if (!found && k <= lim) begin
                // Prefix of length k sits at pattern[len-1 : len-k];
                // its last bit aligns with the newest history bit.
                mask = (one << k) - one;
                pref = pat_ext >> (int'(len) - k);
                if (((sfx ^ pref) & mask) == '0) begin
                    next_prog = LEN_W'(k);
                    found     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/seq_pattern_detector.sv
// Programmable serial pattern detector with overlap select and counter.
// Ports: clk/reset, cfg_* load interface, in_valid/in_bit stream;
// armed, cfg_err, match (registered Moore), match_count (saturating).
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W = 16,
    localparam int LEN_W = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               in_bit,
    output logic               armed,
    output logic               cfg_err,
    output logic               match,
    output logic [CNT_W-1:0]   match_count
);

    det_state_t         state;
    det_state_t         state_nxt;
    logic [MAX_LEN-1:0] pat_q;
    logic [MAX_LEN-1:0] hist_q;
    logic [MAX_LEN:0]   hist_ext;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   prog_q;
    logic [LEN_W-1:0]   prog_nxt;
    logic               ovl_q;
    logic               len_ok;
    logic               accept;
    logic               hit;

    assign len_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    assign accept   = (state == RUN) && in_valid && !cfg_load;
    assign hit      = (prog_nxt == len_q);
    assign hist_ext = {hist_q, in_bit};
    assign armed    = (state == RUN);

    seq_prefix_match #(
        .MAX_LEN(MAX_LEN)
    ) u_pm (
        .pattern  (pat_q),
        .len      (len_q),
        .prog     (prog_q),
        .history  (hist_q),
        .new_bit  (in_bit),
        .next_prog(prog_nxt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (cfg_load) begin
            state_nxt = len_ok ? RUN : IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q       <= '0;
            len_q       <= '0;
            ovl_q       <= 1'b0;
            hist_q      <= '0;
            prog_q      <= '0;
            match       <= 1'b0;
            match_count <= '0;
            cfg_err     <= 1'b0;
        end else if (cfg_load) begin
            // A load always wins over a bit arriving in the same cycle.
            pat_q       <= cfg_pattern;
            len_q       <= cfg_len;
            ovl_q       <= cfg_overlap;
            hist_q      <= '0;
            prog_q      <= '0;
            match       <= 1'b0;
            match_count <= '0;
            cfg_err     <= !len_ok;
        end else if (accept) begin
            match <= hit;
            if (hit) begin
                if (match_count != '1) begin
                    match_count <= match_count + 1'b1;
                end
                if (ovl_q) begin
                    hist_q <= hist_ext[MAX_LEN-1:0];
                    prog_q <= prog_nxt;
                end else begin
                    hist_q <= '0;
                    prog_q <= '0;
                end
            end else begin
                hist_q <= hist_ext[MAX_LEN-1:0];
                prog_q <= prog_nxt;
            end
        end else begin
            match <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Self-checking bench for seq_pattern_detector (default and CNT_W=2).
// Reference model compares against bit history; directed literals pin it.
module tb_seq_pattern_detector;

    logic        clk;
    logic        reset;
    logic        cfg_load;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic        cfg_overlap;
    logic        in_valid;
    logic        in_bit;
    logic        armed;
    logic        cfg_err;
    logic        match;
    logic [15:0] match_count;
    logic        s_armed;
    logic        s_err;
    logic        s_match;
    logic [1:0]  s_count;

    int n_checks;
    int n_fail;

    seq_pattern_detector dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_load   (cfg_load),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .armed      (armed),
        .cfg_err    (cfg_err),
        .match      (match),
        .match_count(match_count)
    );

    seq_pattern_detector #(
        .CNT_W(2)
    ) dut_s (
        .clk        (clk),
        .reset      (reset),
        .cfg_load   (cfg_load),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .armed      (s_armed),
        .cfg_err    (s_err),
        .match      (s_match),
        .match_count(s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d @%0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: keeps the raw accepted-bit history since the last
    // clear; a match is simply "the last len bits equal the pattern".
    logic        m_armed;
    logic        m_err;
    logic        m_match;
    int          m_cnt;
    int          m_cnt2;
    logic [7:0]  m_pat;
    int          m_len;
    logic        m_ovl;
    logic [63:0] m_hist;
    int          m_n;

    function automatic logic hit_f(input logic [63:0] h, input int n,
                                   input logic [7:0] p, input int len);
        logic [63:0] msk;
        if (n < len) return 1'b0;
        msk = (64'd1 << len) - 64'd1;
        return ((h ^ {56'd0, p}) & msk) == 64'd0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_armed <= 1'b0;
            m_err   <= 1'b0;
            m_match <= 1'b0;
            m_cnt   <= 0;
            m_cnt2  <= 0;
            m_pat   <= '0;
            m_len   <= 0;
            m_ovl   <= 1'b0;
            m_hist  <= '0;
            m_n     <= 0;
        end else if (cfg_load) begin
            m_armed <= (cfg_len >= 1 && cfg_len <= 8);
            m_err   <= !(cfg_len >= 1 && cfg_len <= 8);
            m_pat   <= cfg_pattern;
            m_len   <= int'(cfg_len);
            m_ovl   <= cfg_overlap;
            m_hist  <= '0;
            m_n     <= 0;
            m_match <= 1'b0;
            m_cnt   <= 0;
            m_cnt2  <= 0;
        end else if (m_armed && in_valid) begin
            if (hit_f({m_hist[62:0], in_bit}, m_n + 1, m_pat, m_len)) begin
                m_match <= 1'b1;
                m_cnt   <= (m_cnt == 65535) ? m_cnt : m_cnt + 1;
                m_cnt2  <= (m_cnt2 == 3) ? m_cnt2 : m_cnt2 + 1;
                m_hist  <= m_ovl ? {m_hist[62:0], in_bit} : 64'd0;
                m_n     <= m_ovl ? m_n + 1 : 0;
            end else begin
                m_match <= 1'b0;
                m_hist  <= {m_hist[62:0], in_bit};
                m_n     <= m_n + 1;
            end
        end else begin
            m_match <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("armed", 32'(armed), 32'(m_armed));
        chk("cfg_err", 32'(cfg_err), 32'(m_err));
        chk("match", 32'(match), 32'(m_match));
        chk("count", 32'(match_count), 32'(m_cnt));
        chk("s_armed", 32'(s_armed), 32'(m_armed));
        chk("s_err", 32'(s_err), 32'(m_err));
        chk("s_match", 32'(s_match), 32'(m_match));
        chk("s_count", 32'(s_count), 32'(m_cnt2));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l,
                        input logic o);
        cfg_load    = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        tick();
        cfg_load    = 1'b0;
    endtask

    task automatic send(input logic b);
        in_valid = 1'b1;
        in_bit   = b;
        tick();
        in_valid = 1'b0;
    endtask

    // Send n bits MSB first; check match after each against expm.
    task automatic sendv(input string tag, input logic [15:0] bits,
                         input int n, input logic [15:0] expm);
        logic [15:0] tb;
        logic [15:0] te;
        for (int i = 0; i < n; i++) begin
            tb = bits >> (n - 1 - i);
            te = expm >> (n - 1 - i);
            send(tb[0]);
            chk($sformatf("%s_bit%0d", tag, i), 32'(match), 32'(te[0]));
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        in_valid    = 1'b0;
        in_bit      = 1'b0;
        #12;
        reset = 1'b0;
        chk("rst_armed", 32'(armed), 32'd0);
        chk("rst_err", 32'(cfg_err), 32'd0);
        chk("rst_match", 32'(match), 32'd0);
        chk("rst_count", 32'(match_count), 32'd0);

        // Overlapping: 1011011 matches after bits 4 and 7.
        load(8'b1011, 4'd4, 1'b1);
        chk("ovl_armed", 32'(armed), 32'd1);
        chk("ovl_load_match", 32'(match), 32'd0);
        sendv("ovl", 16'b1011011, 7, 16'b0001001);
        chk("ovl_count", 32'(match_count), 32'd2);

        // Non-overlapping: only the first match.
        load(8'b1011, 4'd4, 1'b0);
        chk("novl_count0", 32'(match_count), 32'd0);
        sendv("novl", 16'b1011011, 7, 16'b0001000);
        chk("novl_count", 32'(match_count), 32'd1);

        // Fallback to shorter prefix: 1,0,1,0 -> P=2, then 1,1 matches.
        load(8'b1011, 4'd4, 1'b1);
        sendv("kmp", 16'b101011, 6, 16'b000001);

        // Valid gaps hold progress.
        load(8'b1011, 4'd4, 1'b1);
        sendv("gap_a", 16'b10, 2, 16'b00);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("gap_idle%0d", i), 32'(match), 32'd0);
        end
        sendv("gap_b", 16'b11, 2, 16'b01);
        tick();
        chk("gap_drop", 32'(match), 32'd0);
        chk("gap_count", 32'(match_count), 32'd1);

        // Illegal lengths.
        load(8'b1011, 4'd0, 1'b1);
        chk("len0_err", 32'(cfg_err), 32'd1);
        chk("len0_armed", 32'(armed), 32'd0);
        sendv("len0", 16'b1011, 4, 16'b0000);
        load(8'b1011, 4'd9, 1'b1);
        chk("len9_err", 32'(cfg_err), 32'd1);
        chk("len9_armed", 32'(armed), 32'd0);
        sendv("len9", 16'b11111, 5, 16'b00000);
        chk("len9_count", 32'(match_count), 32'd0);
        load(8'b1011, 4'd4, 1'b1);
        chk("legal_err", 32'(cfg_err), 32'd0);
        chk("legal_armed", 32'(armed), 32'd1);

        // Full-length pattern with leading zeros.
        load(8'b0010_1101, 4'd8, 1'b1);
        sendv("len8", 16'b0000101101, 10, 16'b0000000001);

        // Saturation on the narrow counter.
        load(8'b1, 4'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send(1'b1);
            chk($sformatf("sat_match%0d", i), 32'(s_match), 32'd1);
        end
        chk("sat_count2", 32'(s_count), 32'd3);
        chk("sat_count16", 32'(match_count), 32'd5);

        // Reset mid-stream discards progress.
        load(8'b1011, 4'd4, 1'b1);
        sendv("prerst", 16'b101, 3, 16'b000);
        reset = 1'b1;
        #3;
        reset = 1'b0;
        chk("rst2_armed", 32'(armed), 32'd0);
        chk("rst2_count", 32'(match_count), 32'd0);
        load(8'b1011, 4'd4, 1'b1);
        sendv("postrst", 16'b1, 1, 16'b0);

        // Load colliding with a completing bit: the bit is dropped.
        load(8'b1011, 4'd4, 1'b1);
        sendv("coll", 16'b101, 3, 16'b000);
        cfg_load    = 1'b1;
        cfg_pattern = 8'b1011;
        cfg_len     = 4'd4;
        cfg_overlap = 1'b1;
        in_valid    = 1'b1;
        in_bit      = 1'b1;
        tick();
        cfg_load = 1'b0;
        in_valid = 1'b0;
        chk("coll_match", 32'(match), 32'd0);
        chk("coll_count", 32'(match_count), 32'd0);
        sendv("coll_after", 16'b1, 1, 16'b0);

        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_pattern_detector.md
# seq_pattern_detector

Parameterised successor to the fixed two-bit Moore sequence detector. It detects a runtime-programmable serial bit pattern of 1..MAX_LEN bits on a valid-qualified input stream. Overlapping or non-overlapping matching is selectable, and a saturating match counter is provided. It sits on the serial-input path of the sequence-detect blocks. Its registered Moore `match` output feeds downstream control logic directly.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (≥1).
- CNT_W, 16: width of the match counter.
- LEN_W, $clog2(MAX_LEN+1): derived; width of cfg_len.

- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- cfg_load  in  1  one-cycle strobe that loads cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is expected first, bit [0] last; bits ≥ cfg_len ignored.
- cfg_len  in  LEN_W  pattern length; valid range 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping matches, 0 = history restarts after each match.
- in_valid  in  1  qualifies in_bit.
- in_bit  in  1  serial data bit.
- armed  out  1  high in state RUN.
- cfg_err  out  1  set by a load with illegal cfg_len; cleared by the next legal load.
- match  out  1  registered Moore output; high for the cycle after a completing bit is accepted.
- match_count  out  CNT_W  number of matches since the last load or reset; saturating.

## Operation
- Control FSM states:
  - IDLE: no valid configuration; input is ignored.
  - RUN: detecting.
- Transitions:
  - cfg_load with 1 ≤ cfg_len ≤ MAX_LEN: go to RUN from any state. Latch the config, clear history, match_count and cfg_err.
  - cfg_load with illegal cfg_len: go to IDLE. Set cfg_err, clear history and match_count.
- Detection state is the progress count P, 0..len.
  - P is the length of the longest suffix of the accepted-bit history that equals the first P expected pattern bits (KMP semantics).
  - A bit is accepted when in_valid=1 and state=RUN.
  - A mismatch falls back to the longest valid shorter prefix, not to 0. For example, with pattern 1011, after 1,0,1 the bit 0 gives P=2.
- Match: on acceptance of the bit that brings P to len.
  - Overlap=1: P continues as a proper-suffix fallback, so patterns may share bits.
  - Overlap=0: history is cleared, P=0, and the next match needs len fresh bits.
- match_count increments on the same edge that sets match. It holds at 2^CNT_W−1.
- in_valid=0: P and history hold; match returns to 0 on the next edge.

## Timing
- Reset values: armed=0, cfg_err=0, match=0, match_count=0, state IDLE, P=0. The latched config is don't-care.
- Latency: the completing bit sampled at edge k gives match=1 during cycle k→k+1. One cycle wide unless the next accepted bit also completes a match. For example, pattern "1" or "11" with overlap and consecutive 1s keeps match high in consecutive cycles.
- cfg_load and in_valid in the same cycle: the load wins and the bit is dropped. match is 0 the cycle after a load.
- Reset mid-stream: all progress is discarded. After reload, pre-reset bits never contribute.
- cfg_pattern, cfg_len and cfg_overlap are sampled only on cfg_load. Changes between loads have no effect.
- No combinational path from inputs to outputs.

## Structure
- Shared package seq_det_pkg holds:
  - typedef enum logic {IDLE, RUN} det_state_t.
  - A localparam helper for LEN_W.
- Sub-module seq_prefix_match is combinational.
  - Inputs: the pattern, len, a history register of MAX_LEN bits, and the new bit.
  - Output: next P, computed by parallel prefix compare, longest first.
- The top level holds the FSM, history shift register, match register and counter.

## Test plan
- Overlap, continuous valid: reset; load pattern 1011, len 4, overlap=1; stream 1,0,1,1,0,1,1 → match high after bits 4 and 7; match_count=2.
- Non-overlap: same as above with overlap=0 → match high only after bit 4; match_count=1.
- Valid gaps: pattern 1011, overlap=1; bits 1,0, then 5 idle cycles, then 1,1 → P holds through the gap; a single match after the last bit; match=0 during the gap.
- Illegal length with MAX_LEN=8:
  - Load cfg_len=0 → cfg_err=1, armed=0, no match on any stream.
  - Load cfg_len=9 → same response.
  - Then a legal load → cfg_err=0, armed=1.
- Saturation: CNT_W=2; pattern "1", len 1, overlap=1; five consecutive 1s → match high for 5 cycles; match_count ends at 3.
- Reset mid-stream and load collision:
  - Pattern 1011; send 1,0,1; assert reset; reload; send 1 → no match.
  - Assert cfg_load together with a completing bit → no match; match_count=0.
